// File: rtl/prince_sbox_cms_sched.sv
// Scheduler sharing one pipelined, CMS-masked PRINCE Sbox across all state nibbles.
// Each issue waits for fresh mask randomness. An index/valid pipe as deep as the
// Sbox latency tracks in-flight nibbles and produces the write-back strobes.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for start, all outputs quiet
// S_ISSUE | issuing nibbles 0..NIBBLES-1, one per cycle with randomness
// S_DRAIN | all issued, waiting for the last write-back
// S_DONE  | one-cycle done pulse
module prince_sbox_cms_sched #(
  parameter int NIBBLES  = 16,
  parameter int SBOX_LAT = 2,
  localparam int IW      = $clog2(NIBBLES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          rnd_req,
  input  logic          rnd_valid,
  output logic          sbox_en,
  output logic [IW-1:0] nib_sel,
  output logic          wr_en,
  output logic [IW-1:0] wr_idx
);

  // One extra counter bit so the counters can never wrap within a layer.
  localparam int CW = IW + 1;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t                      state_q, state_d;
  logic [CW-1:0]               issue_cnt_q, issue_cnt_d;
  logic [CW-1:0]               ret_cnt_q, ret_cnt_d;
  logic [SBOX_LAT-1:0]         vld_q, vld_d;
  logic [SBOX_LAT-1:0][IW-1:0] idx_q, idx_d;

  // Next-state, counter updates and all control outputs.
  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    ret_cnt_d   = ret_cnt_q;
    busy        = 1'b0;
    done        = 1'b0;
    rnd_req     = 1'b0;
    sbox_en     = 1'b0;
    nib_sel     = '0;
    wr_en       = vld_q[SBOX_LAT-1];
    // Index is masked when nothing is returning so IDLE reads all-zero.
    wr_idx      = vld_q[SBOX_LAT-1] ? idx_q[SBOX_LAT-1] : '0;
    if (wr_en) begin
      ret_cnt_d = ret_cnt_q + CW'(1);
    end
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_ISSUE;
          issue_cnt_d = '0;
          ret_cnt_d   = '0;
        end
      end
      S_ISSUE: begin
        busy    = 1'b1;
        rnd_req = 1'b1;
        nib_sel = issue_cnt_q[IW-1:0];
        if (rnd_valid) begin
          sbox_en     = 1'b1;
          issue_cnt_d = issue_cnt_q + CW'(1);
          if (issue_cnt_q == LAST) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (wr_en && (ret_cnt_q == LAST)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Index/valid shift pipe mirroring the Sbox register stages; bubbles ride along.
  always_comb begin
    vld_d    = vld_q;
    idx_d    = idx_q;
    vld_d[0] = sbox_en;
    idx_d[0] = nib_sel;
    for (int i = 1; i < SBOX_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      idx_d[i] = idx_q[i-1];
    end
  end

  // State, counters and pipe registers; reset drops every in-flight nibble.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
      vld_q       <= '0;
      idx_q       <= '0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      ret_cnt_q   <= ret_cnt_d;
      vld_q       <= vld_d;
      idx_q       <= idx_d;
    end
  end

endmodule

// File: tb/tb_prince_sbox_cms_sched.sv
// Bench for prince_sbox_cms_sched: table-driven bubble patterns, hand-written
// reset/back-to-back sequences and random randomness-valid patterns, all checked
// cycle by cycle against an event-time model built from the issue/return rules.
module tb_prince_sbox_cms_sched;

  localparam int NIB = 16;
  localparam int LAT = 2;

  logic       clk = 1'b0;
  logic       rst, start, rnd_valid;
  logic       busy, done, rnd_req, sbox_en, wr_en;
  logic [3:0] nib_sel, wr_idx;

  int n_checks = 0;
  int n_pass   = 0;
  bit rv [0:127];

  prince_sbox_cms_sched #(.NIBBLES(NIB), .SBOX_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rnd_req(rnd_req), .rnd_valid(rnd_valid), .sbox_en(sbox_en),
    .nib_sel(nib_sel), .wr_en(wr_en), .wr_idx(wr_idx)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    string       name;
    logic [63:0] lowmask;   // bit c set: rnd_valid low in cycle c
    bit          poke;      // extra start pulses during ISSUE and at done
    int          exp_done;
  } vec_t;

  task automatic check_vec(input string name, input logic [12:0] act, input logic [12:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got {busy,done,req,en,sel,wr,idx}=%b expected %b", name, act, exp);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Called just after a rising edge; each cycle checks outputs at the falling edge.
  task automatic idle_check(input int n, input string name);
    for (int c = 0; c < n; c++) begin
      start     = 1'b0;
      rnd_valid = 1'b1;
      @(negedge clk);
      check_vec($sformatf("%s c=%0d", name, c),
                {busy, done, rnd_req, sbox_en, nib_sel, wr_en, wr_idx}, 13'd0);
      @(posedge clk); #1;
    end
  endtask

  // One layer with start in cycle 0 and rnd_valid from rv[]. The model finds the
  // issue cycles as the first NIB cycles >= 1 with randomness available; returns
  // land LAT later and done follows the last return.
  task automatic run_layer(input string name, input bit poke, output int done_seen);
    int          iss_t [NIB];
    int          k, c0, last_wr, cnt;
    logic        e_busy, e_done, e_req, e_en, e_wr;
    logic [3:0]  e_sel, e_idx;
    logic [12:0] act;
    k  = 0;
    c0 = 1;
    while (k < NIB && c0 < 128) begin
      if (rv[c0]) begin
        iss_t[k] = c0;
        k++;
      end
      c0++;
    end
    last_wr   = iss_t[NIB-1] + LAT;
    done_seen = -1;
    for (int c = 0; c <= last_wr + 1; c++) begin
      start     = (c == 0) || (poke && (c == 8 || c == last_wr + 1));
      rnd_valid = rv[c];
      @(negedge clk);
      e_busy = (c >= 1) && (c <= last_wr);
      e_done = (c == last_wr + 1);
      e_req  = (c >= 1) && (c <= iss_t[NIB-1]);
      e_en   = 1'b0;
      e_wr   = 1'b0;
      e_idx  = '0;
      cnt    = 0;
      for (int j = 0; j < NIB; j++) begin
        if (iss_t[j] < c) cnt++;
        if (iss_t[j] == c) e_en = 1'b1;
        if (iss_t[j] + LAT == c) begin
          e_wr  = 1'b1;
          e_idx = 4'(j);
        end
      end
      e_sel = e_req ? 4'(cnt) : 4'd0;
      act = {busy, done, rnd_req, sbox_en, nib_sel, wr_en, (wr_en ? wr_idx : 4'd0)};
      check_vec($sformatf("%s c=%0d", name, c), act,
                {e_busy, e_done, e_req, e_en, e_sel, e_wr, e_idx});
      if (done === 1'b1 && done_seen < 0) done_seen = c;
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic fill_rv(input logic [63:0] lowmask);
    for (int c = 0; c < 128; c++) rv[c] = (c < 64) ? !lowmask[c] : 1'b1;
  endtask

  initial begin
    vec_t vecs [6];
    int   ds, ds2;

    vecs[0] = '{"plain",      64'h0,                                 1'b0, 19};
    vecs[1] = '{"bub5_6",     (64'h1 << 5) | (64'h1 << 6),           1'b0, 21};
    vecs[2] = '{"bub_first",  64'h1 << 1,                            1'b0, 20};
    vecs[3] = '{"bub_last",   64'h1 << 16,                           1'b0, 20};
    vecs[4] = '{"bub_after",  64'h1 << 17,                           1'b0, 19};
    vecs[5] = '{"poke_start", (64'h1 << 5) | (64'h1 << 6),           1'b1, 21};

    rst = 1'b1; start = 1'b0; rnd_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idle_check(4, "reset_idle");

    foreach (vecs[i]) begin
      fill_rv(vecs[i].lowmask);
      run_layer(vecs[i].name, vecs[i].poke, ds);
      check_int({"done_cycle ", vecs[i].name}, ds, vecs[i].exp_done);
      idle_check(2, {"post ", vecs[i].name});
    end

    // A multi-bubble pattern: cycles 1,2,3,8,16 have no randomness.
    fill_rv((64'h1 << 1) | (64'h1 << 2) | (64'h1 << 3) | (64'h1 << 8) | (64'h1 << 16));
    run_layer("multi_bub", 1'b0, ds);
    check_int("done_cycle multi_bub", ds, 24);
    idle_check(2, "post multi_bub");

    // Back-to-back: second start lands in the first IDLE cycle after done.
    fill_rv(64'h0);
    run_layer("b2b_a", 1'b0, ds);
    run_layer("b2b_b", 1'b0, ds2);
    check_int("done_cycle b2b_a", ds, 19);
    check_int("done_cycle b2b_b", ds2, 19);
    idle_check(2, "post b2b");

    // Reset in cycle 10 of a layer: nothing in flight may surface afterwards.
    for (int c = 0; c < 10; c++) begin
      start     = (c == 0);
      rnd_valid = 1'b1;
      @(posedge clk); #1;
    end
    start = 1'b0;
    rst   = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle_check(6, "after_abort");
    fill_rv(64'h0);
    run_layer("after_abort_layer", 1'b0, ds);
    check_int("done_cycle after_abort_layer", ds, 19);
    idle_check(2, "post after_abort_layer");

    // Random randomness availability against the event-time model.
    for (int it = 0; it < 20; it++) begin
      for (int c = 0; c < 128; c++) rv[c] = (c >= 60) ? 1'b1 : ($urandom_range(0, 3) != 0);
      run_layer($sformatf("rand%0d", it), ($urandom_range(0, 1) == 1), ds);
      idle_check(1, $sformatf("post rand%0d", it));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
